// File: rtl/selftest_scheduler.sv
// rtl/selftest_scheduler.sv - runtime self-test sequencer: pipeline stall, ALU BIST, ECC scrub of data memory
// Status outputs are sticky from REPORT until the next triggered run.
module selftest_scheduler #(
  parameter logic [31:0] GOLDEN_SIG   = 32'h81c6f051,
  parameter int          DMEM_WORDS   = 64,
  parameter int          AW           = 6,
  parameter int          BIST_TIMEOUT = 1024,
  parameter int          PERIOD       = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          period_en,
  output logic          stall_req,
  input  logic          stall_ack,
  output logic          bist_en,
  input  logic          bist_done,
  input  logic [31:0]   bist_sig,
  output logic          scrub_re,
  output logic          scrub_we,
  output logic [AW-1:0] scrub_addr,
  output logic [31:0]   scrub_wdata,
  input  logic [31:0]   scrub_rdata,
  input  logic          s_err,
  input  logic          d_err,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          alu_fail,
  output logic          ecc_uncorr,
  output logic          timeout_err,
  output logic [7:0]    ecc_corr_cnt
);

  localparam int TW = $clog2(BIST_TIMEOUT + 1);
  localparam int PW = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STALL, S_BIST, S_RD, S_CHK, S_WB, S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          stall_q, stall_d;
  logic          alu_fail_q, alu_fail_d;
  logic          ecc_uncorr_q, ecc_uncorr_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;
  logic [7:0]    corr_cnt_q, corr_cnt_d;
  logic          trigger;
  logic          advance;

  assign trigger = start || (period_en && (per_cnt_q == PW'(PERIOD - 1)));

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = '0;
    tmo_cnt_d    = tmo_cnt_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    stall_d      = stall_q;
    alu_fail_d   = alu_fail_q;
    ecc_uncorr_d = ecc_uncorr_q;
    timeout_d    = timeout_q;
    pass_d       = pass_q;
    corr_cnt_d   = corr_cnt_q;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          alu_fail_d   = 1'b0;
          ecc_uncorr_d = 1'b0;
          timeout_d    = 1'b0;
          pass_d       = 1'b0;
          corr_cnt_d   = '0;
          busy_d       = 1'b1;
          stall_d      = 1'b1;
          addr_d       = '0;
          tmo_cnt_d    = '0;
          state_d      = S_STALL;
        end else if (period_en) begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      S_STALL: begin
        if (stall_ack) state_d = S_BIST;
      end
      S_BIST: begin
        // A done on the last allowed cycle still wins over the timeout.
        if (bist_done) begin
          if (bist_sig != GOLDEN_SIG) alu_fail_d = 1'b1;
          state_d = S_RD;
        end else if (tmo_cnt_q == TW'(BIST_TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          alu_fail_d = 1'b1;
          state_d    = S_RD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_RD: state_d = S_CHK;
      S_CHK: begin
        rdata_d = scrub_rdata;
        if (d_err) begin
          ecc_uncorr_d = 1'b1;
          advance      = 1'b1;
        end else if (s_err) begin
          state_d = S_WB;
        end else begin
          advance = 1'b1;
        end
      end
      S_WB: begin
        if (corr_cnt_q != 8'hff) corr_cnt_d = corr_cnt_q + 1'b1;
        advance = 1'b1;
      end
      S_REPORT: begin
        pass_d  = !(alu_fail_q || ecc_uncorr_q || timeout_q);
        busy_d  = 1'b0;
        stall_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == AW'(DMEM_WORDS - 1)) begin
        state_d = S_REPORT;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      per_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      stall_q      <= 1'b0;
      alu_fail_q   <= 1'b0;
      ecc_uncorr_q <= 1'b0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      corr_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
      alu_fail_q   <= alu_fail_d;
      ecc_uncorr_q <= ecc_uncorr_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
      corr_cnt_q   <= corr_cnt_d;
    end
  end

  assign stall_req    = stall_q;
  assign bist_en      = (state_q == S_BIST);
  assign scrub_re     = (state_q == S_RD);
  assign scrub_we     = (state_q == S_WB);
  assign scrub_addr   = addr_q;
  assign scrub_wdata  = rdata_q;
  assign busy         = busy_q;
  assign done         = (state_q == S_REPORT);
  assign pass         = pass_q;
  assign alu_fail     = alu_fail_q;
  assign ecc_uncorr   = ecc_uncorr_q;
  assign timeout_err  = timeout_q;
  assign ecc_corr_cnt = corr_cnt_q;

endmodule
